// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// ps2_key_tracker : PS/2 frame receiver with make/break key tracking
// Revision: 1.0
// ============================================================================
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       key_code,
  output logic             key_valid,
  output logic             new_key,
  output logic [CNT_W-1:0] press_cnt,
  output logic             frame_err
);

  localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        c_BREAK   = 8'hF0;
  localparam logic [7:0]        c_EXT     = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  logic [2:0]        r_clk_sync;
  logic [1:0]        r_dat_sync;
  logic [3:0]        r_bit_cnt;
  logic [9:0]        r_shift;
  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_byte_rdy;
  logic [7:0]        r_byte;

  logic              w_fall;
  logic [10:0]       w_frame;
  logic              w_frame_ok;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        w_code_nxt;
  logic              w_valid_nxt;
  logic              w_new_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Bit 0 of each sync chain is the first flop; bit 2 of the clock chain is the edge-detect history.
  assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_frame    = {r_dat_sync[1], r_shift};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_byte_rdy <= 1'b0;
      r_byte     <= '0;
      frame_err  <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_byte_rdy <= 1'b0;
      frame_err  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        r_shift  <= w_frame[10:1];
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            r_byte_rdy <= 1'b1;
            r_byte     <= w_frame[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt == 4'd0) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == c_TO_LAST) begin
        // Stalled mid-frame: drop the partial frame and report it.
        r_bit_cnt <= '0;
        r_to_cnt  <= '0;
        frame_err <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      new_key   <= 1'b0;
      press_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      key_code  <= w_code_nxt;
      key_valid <= w_valid_nxt;
      new_key   <= w_new_nxt;
      press_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = key_code;
    w_valid_nxt = key_valid;
    w_new_nxt   = 1'b0;
    w_cnt_nxt   = press_cnt;
    if (r_byte_rdy) begin
      case (r_state)
        ST_IDLE: begin
          if (r_byte == c_BREAK) begin
            w_state_nxt = ST_BREAK;
          end else if (r_byte != c_EXT) begin
            w_state_nxt = ST_HELD;
            w_code_nxt  = r_byte;
            w_valid_nxt = 1'b1;
            w_new_nxt   = 1'b1;
            w_cnt_nxt   = press_cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (r_byte == c_BREAK) begin
            w_state_nxt = ST_BREAK;
          end else if (r_byte != c_EXT && r_byte != key_code) begin
            w_code_nxt = r_byte;
            w_new_nxt  = 1'b1;
            w_cnt_nxt  = press_cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (r_byte != c_BREAK && r_byte != c_EXT) begin
            if (key_valid && r_byte == key_code) begin
              w_state_nxt = ST_IDLE;
              w_code_nxt  = '0;
              w_valid_nxt = 1'b0;
            end else begin
              // Release of some other key: fall back to whatever is still held.
              w_state_nxt = key_valid ? ST_HELD : ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// tb_ps2_key_tracker : self-checking bench for ps2_key_tracker
// Revision: 1.0
// ============================================================================
module tb_ps2_key_tracker;

  localparam int TO   = 300;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_valid;
  logic       new_key;
  logic [7:0] press_cnt;
  logic       frame_err;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_valid(key_valid), .new_key(new_key),
    .press_cnt(press_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int nk_seen  = 0;
  int fe_seen  = 0;

  always @(negedge clk) begin
    if (new_key)   nk_seen++;
    if (frame_err) fe_seen++;
  end

  // Reference model: held key, pending-release flag, press count.
  logic [7:0] m_code;
  logic       m_valid;
  logic       m_brk;
  logic [7:0] m_cnt;

  typedef struct {
    logic [7:0] b;
    int         kind;
    logic [7:0] code;
    logic       valid;
    logic [7:0] cnt;
    int         nk;
    int         fe;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(input logic [7:0] b, input int kind, input logic [7:0] code,
                               input logic valid, input logic [7:0] cnt, input int nk, input int fe);
    vec_t v;
    v.b = b; v.kind = kind; v.code = code; v.valid = valid; v.cnt = cnt; v.nk = nk; v.fe = fe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_valid = 1'b0; m_brk = 1'b0; m_cnt = 8'h00;
  endtask

  task automatic model_apply(input logic [7:0] b, input int kind, output int enk, output int efe);
    enk = 0;
    efe = 0;
    if (kind != 0) begin
      efe = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_brk = m_brk;
    end else if (m_brk) begin
      m_brk = 1'b0;
      if (m_valid && b == m_code) begin
        m_valid = 1'b0;
        m_code  = 8'h00;
      end
    end else if (!(m_valid && b == m_code)) begin
      m_code  = b;
      m_valid = 1'b1;
      m_cnt++;
      enk = 1;
    end
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit low, 3 start bit high
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9]  = ~f[9];
    if (kind == 2) f[10] = 1'b0;
    if (kind == 3) f[0]  = 1'b1;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_data = bits[i];
      repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk); ps2_clk = 1'b1;
    end
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] b, input int kind);
    int nk0, fe0, enk, efe;
    nk0 = nk_seen;
    fe0 = fe_seen;
    send_bits(mk_frame(b, kind), 11);
    repeat (6) @(negedge clk);
    model_apply(b, kind, enk, efe);
    check({tag, " key_code"},  key_code,        m_code);
    check({tag, " key_valid"}, key_valid,       m_valid);
    check({tag, " press_cnt"}, press_cnt,       m_cnt);
    check({tag, " new_key"},   nk_seen - nk0,   enk);
    check({tag, " frame_err"}, fe_seen - fe0,   efe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nk0, fe0, enk, efe, guard;
    logic [10:0] f;
    logic [7:0] b;
    int kind, r;

    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset key_code",  key_code,  8'h00);
    check("reset key_valid", key_valid, 1'b0);
    check("reset new_key",   new_key,   1'b0);
    check("reset press_cnt", press_cnt, 8'h00);
    check("reset frame_err", frame_err, 1'b0);

    // First press, cycle-exact: outputs move on the 4th posedge after ps2_clk falls.
    f = mk_frame(8'h1C, 0);
    send_bits(f, 10);
    @(negedge clk); ps2_data = f[10];
    repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("latency early key_valid", key_valid, 1'b0);
    @(negedge clk);
    check("latency key_code",  key_code,  8'h1C);
    check("latency key_valid", key_valid, 1'b1);
    check("latency new_key",   new_key,   1'b1);
    check("latency press_cnt", press_cnt, 8'd1);
    @(negedge clk);
    check("latency new_key pulse end", new_key, 1'b0);
    repeat (HALF - 5) @(negedge clk);
    ps2_clk = 1'b1;
    model_apply(8'h1C, 0, enk, efe);

    vt.push_back(mkv(8'h1C, 0, 8'h1C, 1, 1, 0, 0));
    vt.push_back(mkv(8'h1C, 0, 8'h1C, 1, 1, 0, 0));
    vt.push_back(mkv(8'h1C, 0, 8'h1C, 1, 1, 0, 0));
    vt.push_back(mkv(8'hF0, 0, 8'h1C, 1, 1, 0, 0));
    vt.push_back(mkv(8'h1C, 0, 8'h00, 0, 1, 0, 0));
    vt.push_back(mkv(8'h1C, 0, 8'h1C, 1, 2, 1, 0));
    vt.push_back(mkv(8'h32, 0, 8'h32, 1, 3, 1, 0));
    vt.push_back(mkv(8'hF0, 0, 8'h32, 1, 3, 0, 0));
    vt.push_back(mkv(8'h1C, 0, 8'h32, 1, 3, 0, 0));
    vt.push_back(mkv(8'h32, 0, 8'h32, 1, 3, 0, 0));
    vt.push_back(mkv(8'hF0, 0, 8'h32, 1, 3, 0, 0));
    vt.push_back(mkv(8'h32, 0, 8'h00, 0, 3, 0, 0));
    vt.push_back(mkv(8'h1C, 1, 8'h00, 0, 3, 0, 1));
    vt.push_back(mkv(8'h1C, 0, 8'h1C, 1, 4, 1, 0));
    vt.push_back(mkv(8'hE0, 0, 8'h1C, 1, 4, 0, 0));
    vt.push_back(mkv(8'hF0, 0, 8'h1C, 1, 4, 0, 0));
    vt.push_back(mkv(8'hE0, 0, 8'h1C, 1, 4, 0, 0));
    vt.push_back(mkv(8'h1C, 1, 8'h1C, 1, 4, 0, 1));
    vt.push_back(mkv(8'h1C, 0, 8'h00, 0, 4, 0, 0));
    vt.push_back(mkv(8'hE0, 0, 8'h00, 0, 4, 0, 0));
    vt.push_back(mkv(8'hF0, 0, 8'h00, 0, 4, 0, 0));
    vt.push_back(mkv(8'h33, 0, 8'h00, 0, 4, 0, 0));
    vt.push_back(mkv(8'h33, 0, 8'h33, 1, 5, 1, 0));
    vt.push_back(mkv(8'h45, 2, 8'h33, 1, 5, 0, 1));
    vt.push_back(mkv(8'h45, 3, 8'h33, 1, 5, 0, 1));
    vt.push_back(mkv(8'hF0, 0, 8'h33, 1, 5, 0, 0));
    vt.push_back(mkv(8'h33, 0, 8'h00, 0, 5, 0, 0));

    foreach (vt[i]) begin
      nk0 = nk_seen;
      fe0 = fe_seen;
      send_bits(mk_frame(vt[i].b, vt[i].kind), 11);
      repeat (6) @(negedge clk);
      model_apply(vt[i].b, vt[i].kind, enk, efe);
      check($sformatf("row%0d key_code", i),  key_code,      vt[i].code);
      check($sformatf("row%0d key_valid", i), key_valid,     vt[i].valid);
      check($sformatf("row%0d press_cnt", i), press_cnt,     vt[i].cnt);
      check($sformatf("row%0d new_key", i),   nk_seen - nk0, vt[i].nk);
      check($sformatf("row%0d frame_err", i), fe_seen - fe0, vt[i].fe);
    end

    // Partial frame followed by silence must time out exactly once.
    nk0 = nk_seen;
    fe0 = fe_seen;
    send_bits(mk_frame(8'h45, 0), 5);
    repeat (TO + 20) @(negedge clk);
    check("timeout frame_err", fe_seen - fe0, 1);
    check("timeout new_key",   nk_seen - nk0, 0);
    check("timeout key_valid", key_valid,     m_valid);
    frame_and_check("after timeout", 8'h45, 0);
    check("after timeout key_code 45", key_code, 8'h45);

    // Reset in the middle of a frame while 0x45 is held.
    f = mk_frame(8'h1C, 0);
    send_bits(f, 7);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    check("midreset key_code",  key_code,  8'h00);
    check("midreset key_valid", key_valid, 1'b0);
    check("midreset press_cnt", press_cnt, 8'h00);
    check("midreset new_key",   new_key,   1'b0);
    check("midreset frame_err", frame_err, 1'b0);
    nk0 = nk_seen;
    send_bits(f >> 7, 4);
    repeat (10) @(negedge clk);
    check("tail new_key",   nk_seen - nk0, 0);
    check("tail key_valid", key_valid,     1'b0);
    repeat (TO + 20) @(negedge clk);
    frame_and_check("post reset", 8'h1C, 0);

    // Rollover presses until the press counter wraps to zero.
    guard = 0;
    do begin
      frame_and_check("wrap", (guard % 2 == 0) ? 8'h10 : 8'h11, 0);
      guard++;
    end while (m_cnt != 8'h00 && guard < 300);
    check("wrap press_cnt zero", press_cnt, 8'h00);
    check("wrap frame count", guard, 255);

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      b = 8'hF0;
      else if (r == 3) b = 8'hE0;
      else if (r <= 7) begin
        case ($urandom_range(0, 3))
          0: b = 8'h1C;
          1: b = 8'h32;
          2: b = 8'h45;
          default: b = 8'h33;
        endcase
      end else b = 8'($urandom);
      kind = ($urandom_range(0, 11) < 9) ? 0 : int'($urandom_range(1, 3));
      frame_and_check($sformatf("rand%0d", i), b, kind);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
